// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file types and widths, plus the write-port source select used by the arbiter.
package regfile_wb_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small FIFO holding long-latency writeback requests; head is visible combinationally.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: MEM/WB writeback vs. queued long-latency results,
// with a per-register busy mask for decode stalls and an anti-starvation pipeline hold.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N          = RF_ADDR_W,
    parameter int M          = RF_DATA_W,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_we,
    input  logic [N-1:0] pipe_a,
    input  logic [M-1:0] pipe_wd,
    input  logic         lu_valid,
    input  logic [N-1:0] lu_a,
    input  logic [M-1:0] lu_wd,
    output logic         lu_ready,
    output logic [N-1:0] a3,
    output logic [M-1:0] wd3,
    output logic         we3,
    input  logic [N-1:0] chk_a1,
    input  logic [N-1:0] chk_a2,
    input  logic [N-1:0] chk_ad,
    output logic         busy_stall,
    output logic         pipe_hold
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIM) + 1;

    logic [N+M-1:0]      head;
    logic [N-1:0]        head_a;
    logic [M-1:0]        head_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic                push;
    logic                pop;
    wb_src_e             src;
    logic [N-1:0]        sel_a;
    logic [M-1:0]        sel_d;
    logic [(1<<N)-1:0]   busy;
    logic [SW-1:0]       starve_cnt;

    assign head_a = head[N+M-1:M];
    assign head_d = head[M-1:0];

    wb_fifo #(
        .W     (N + M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({lu_a, lu_wd}),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        src = SRC_NONE;
        if (pipe_hold && !fifo_empty) begin
            src = SRC_FIFO;
        end else if (pipe_we) begin
            src = SRC_PIPE;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (lu_valid) begin
            src = SRC_BYP;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_d = '0;
        case (src)
            SRC_PIPE: begin sel_a = pipe_a; sel_d = pipe_wd; end
            SRC_FIFO: begin sel_a = head_a; sel_d = head_d; end
            SRC_BYP:  begin sel_a = lu_a;   sel_d = lu_wd;   end
            default:  begin sel_a = '0;     sel_d = '0;      end
        endcase
    end

    // r0 writes are swallowed here; the bus is zeroed whenever nothing is written.
    assign we3 = (src != SRC_NONE) && (sel_a != '0);
    assign a3  = we3 ? sel_a : '0;
    assign wd3 = we3 ? sel_d : '0;

    assign pop      = (src == SRC_FIFO);
    assign lu_ready = !fifo_full || pop;
    assign push     = lu_valid && lu_ready && (src != SRC_BYP) && (lu_a != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            // Set is applied last so it wins over a same-cycle clear.
            if (pop) begin
                busy[head_a] <= 1'b0;
            end
            if (push) begin
                busy[lu_a] <= 1'b1;
            end
        end
    end

    function automatic logic is_busy(input logic [N-1:0] a, input logic [(1<<N)-1:0] mask);
        return (a != '0) && mask[a];
    endfunction

    assign busy_stall = is_busy(chk_a1, busy) | is_busy(chk_a2, busy) | is_busy(chk_ad, busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else begin
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_LIM - 1)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (pop) begin
                pipe_hold <= 1'b0;
            end else if (!fifo_empty && starve_cnt == SW'(STARVE_LIM - 1)) begin
                pipe_hold <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: expected regfile writes go into a scoreboard queue, a negedge monitor compares them.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_a;
    logic [31:0] pipe_wd;
    logic        lu_valid;
    logic [4:0]  lu_a;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic [4:0]  chk_ad;
    logic        busy_stall;
    logic        pipe_hold;

    int checks;
    int failures;
    wb_req_t sb[$];
    wb_req_t mon_e;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_a     (pipe_a),
        .pipe_wd    (pipe_wd),
        .lu_valid   (lu_valid),
        .lu_a       (lu_a),
        .lu_wd      (lu_wd),
        .lu_ready   (lu_ready),
        .a3         (a3),
        .wd3        (wd3),
        .we3        (we3),
        .chk_a1     (chk_a1),
        .chk_a2     (chk_a2),
        .chk_ad     (chk_ad),
        .busy_stall (busy_stall),
        .pipe_hold  (pipe_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we  = pw;
        pipe_a   = pa;
        pipe_wd  = pd;
        lu_valid = lv;
        lu_a     = la;
        lu_wd    = ld;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    always @(negedge clk) begin
        if (pipe_we && pipe_hold) begin
            failures++;
            $display("FAIL protocol: pipe_we driven while pipe_hold high");
        end
        if (we3 === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got a3=%0d wd3=%0h expected no write", a3, wd3);
            end else begin
                mon_e = sb.pop_front();
                if (a3 !== mon_e.addr || wd3 !== mon_e.data) begin
                    failures++;
                    $display("FAIL wr_data: got a3=%0d wd3=%0h expected a3=%0d wd3=%0h",
                             a3, wd3, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        chk_a1   = '0;
        chk_a2   = '0;
        chk_ad   = '0;
        drive(0, 0, 0, 0, 0, 0);

        // 1) reset and idle
        #2;
        chk("rst_we3", we3, 1'b0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_lu_ready", lu_ready, 1'b1);
        chk("rst_busy_stall", busy_stall, 1'b0);
        chk("rst_pipe_hold", pipe_hold, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        #1;
        chk("idle_we3", we3, 1'b0);
        chk("idle_lu_ready", lu_ready, 1'b1);
        chk("idle_pipe_hold", pipe_hold, 1'b0);

        // 2) bypass into empty FIFO
        drive(0, 0, 0, 1, 5, 32'h11);
        expect_wr(5, 32'h11);
        #1;
        chk("byp_lu_ready", lu_ready, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk_a1 = 5;
        #1;
        chk("byp_no_busy", busy_stall, 1'b0);

        // 3) pipe wins, long-latency result queued then drained
        tick();
        chk_a1 = 0;
        drive(1, 3, 32'hA, 1, 7, 32'hB);
        expect_wr(3, 32'hA);
        #1;
        chk("t3_lu_ready", lu_ready, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk_a1 = 7;
        expect_wr(7, 32'hB);
        #1;
        chk("t3_busy_r7", busy_stall, 1'b1);
        tick();
        #1;
        chk("t3_busy_clr", busy_stall, 1'b0);
        chk_a1 = 0;

        // 4) fill the FIFO while pipe holds the port
        for (int k = 0; k < 4; k++) begin
            drive(1, 5'(20 + k), 32'h100 + k, 1, 5'(8 + k), 32'h200 + k);
            expect_wr(5'(20 + k), 32'h100 + k);
            #1;
            chk("fill_lu_ready", lu_ready, 1'b1);
            tick();
        end
        drive(1, 24, 32'h104, 1, 12, 32'h20C);
        expect_wr(24, 32'h104);
        #1;
        chk("full_lu_ready", lu_ready, 1'b0);
        tick();
        drive(0, 0, 0, 1, 12, 32'h20C);
        expect_wr(8, 32'h200);
        #1;
        chk("drain_push_lu_ready", lu_ready, 1'b1);
        tick();

        // 5) starvation: eight denied cycles then pipe_hold
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'(16 + i), 32'h300 + i, (i == 0), 13, 32'h20D);
            expect_wr(5'(16 + i), 32'h300 + i);
            #1;
            chk("starve_no_hold", pipe_hold, 1'b0);
            if (i == 0) begin
                chk("still_full_lu_ready", lu_ready, 1'b0);
                chk_a1 = 8;
                #1;
                chk("busy_r8_cleared", busy_stall, 1'b0);
                chk_a1 = 12;
                #1;
                chk("busy_r12_set", busy_stall, 1'b1);
                chk_a1 = 0;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        expect_wr(9, 32'h201);
        #1;
        chk("hold_set", pipe_hold, 1'b1);
        tick();
        drive(1, 27, 32'h500, 0, 0, 0);
        expect_wr(27, 32'h500);
        #1;
        chk("hold_clr", pipe_hold, 1'b0);
        tick();

        // 6) r0 handling and async reset with three queued
        drive(0, 0, 0, 1, 0, 32'hDEAD);
        expect_wr(10, 32'h202);
        #1;
        chk("r0_lu_ready", lu_ready, 1'b1);
        tick();
        drive(1, 0, 32'hBEEF, 1, 14, 32'h40E);
        #1;
        chk("r0_pipe_we3", we3, 1'b0);
        chk_a1 = 0;
        chk_a2 = 0;
        chk_ad = 0;
        #1;
        chk("r0_never_busy", busy_stall, 1'b0);
        tick();
        chk_ad = 14;
        #1;
        chk("r14_busy", busy_stall, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        chk_a1 = 11;
        chk_a2 = 12;
        chk_ad = 14;
        #1;
        chk("mid_rst_we3", we3, 1'b0);
        chk("mid_rst_mask", busy_stall, 1'b0);
        chk("mid_rst_lu_ready", lu_ready, 1'b1);
        chk("mid_rst_hold", pipe_hold, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_a1 = 0;
        chk_a2 = 0;
        chk_ad = 0;
        tick();
        tick();
        drive(0, 0, 0, 1, 5, 32'h55);
        expect_wr(5, 32'h55);
        #1;
        chk("post_rst_lu_ready", lu_ready, 1'b1);
        chk("post_rst_bypass", we3, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
